// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: word width, reset PC and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int CPU_WORD_W = 16;

  localparam logic [CPU_WORD_W-1:0] CPU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Bus bundle between the fetch unit (master), instruction memory and the
// control unit (slave side).
interface cpu_fetch_unit_if;
  import cpu_pkg::*;

  // Memory side is req/ack: o_imem_req stays high with o_imem_addr stable
  // until a cycle with i_imem_ack=1, which delivers i_imem_data and ends the
  // request. Control side is valid/ready: o_instr is retired on any cycle
  // where o_instr_valid and i_exec_ready are both 1; the redirect inputs
  // (i_pc, i_pc_we, i_pc_increment) are only sampled on that retire cycle.
  logic [CPU_WORD_W-1:0] o_imem_addr;
  logic                  o_imem_req;
  logic                  i_imem_ack;
  logic [CPU_WORD_W-1:0] i_imem_data;
  logic [CPU_WORD_W-1:0] o_instr;
  logic                  o_instr_valid;
  logic                  i_exec_ready;
  logic [CPU_WORD_W-1:0] i_pc;
  logic                  i_pc_we;
  logic                  i_pc_increment;
  logic [CPU_WORD_W-1:0] o_pc;
  logic [CPU_WORD_W-1:0] o_retired;

  modport master (
    output o_imem_addr, o_imem_req, o_instr, o_instr_valid, o_pc, o_retired,
    input  i_imem_ack, i_imem_data, i_exec_ready, i_pc, i_pc_we, i_pc_increment
  );

  modport slave (
    input  o_imem_addr, o_imem_req, o_instr, o_instr_valid, o_pc, o_retired,
    output i_imem_ack, i_imem_data, i_exec_ready, i_pc, i_pc_we, i_pc_increment
  );

endinterface

// File: rtl/cpu_program_counter.sv
// Program counter register: load has priority over increment, increment
// wraps naturally at the word width, otherwise the value holds.
module cpu_program_counter
  import cpu_pkg::*;
#(
  parameter logic [CPU_WORD_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [CPU_WORD_W-1:0] i_load_pc,
  output logic [CPU_WORD_W-1:0] o_pc
);

  logic [CPU_WORD_W-1:0] pc_q;
  logic [CPU_WORD_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (i_load) begin
      pc_d = i_load_pc;
    end else if (i_inc) begin
      pc_d = pc_q + CPU_WORD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc = pc_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the word
// for the control unit and applies its PC redirect when the word retires.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [CPU_WORD_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cpu_fetch_unit_if.master  bus,
  output fetch_state_e      o_state
);

  fetch_state_e          state_q, state_d;
  logic                  rst_release_q;
  logic [CPU_WORD_W-1:0] instr_q, instr_d;
  logic [CPU_WORD_W-1:0] retired_q, retired_d;
  logic                  pc_load;
  logic                  pc_inc;
  logic [CPU_WORD_W-1:0] pc;

  cpu_program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (pc_load),
    .i_inc     (pc_inc),
    .i_load_pc (bus.i_pc),
    .o_pc      (pc)
  );

  // The FSM stays in RESET for one full cycle after reset is released, so
  // the first request appears on the second rising edge after deassertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_release_q <= 1'b0;
    end else begin
      rst_release_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    unique case (state_q)
      RESET: begin
        if (rst_release_q) state_d = FETCH;
      end
      FETCH: begin
        if (bus.i_imem_ack) begin
          instr_d = bus.i_imem_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_exec_ready) begin
          pc_load   = bus.i_pc_we;
          pc_inc    = bus.i_pc_increment & ~bus.i_pc_we;
          retired_d = retired_q + CPU_WORD_W'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RESET;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decode only registered state; no input reaches an output.
  assign bus.o_imem_addr   = pc;
  assign bus.o_imem_req    = (state_q == FETCH);
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_valid = (state_q == HOLD);
  assign bus.o_pc          = pc;
  assign bus.o_retired     = retired_q;
  assign o_state           = state_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model.
module tb_cpu_fetch_unit;
  import cpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  // ---------------- clock / reset ----------------
  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  cpu_fetch_unit_if bus ();
  fetch_state_e     dbg_state;

  cpu_fetch_unit #(
    .RESET_PC (RST_PC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ack, input logic [15:0] data, input logic ready,
                       input logic we, input logic inc, input logic [15:0] pc);
    bus.i_imem_ack     = ack;
    bus.i_imem_data    = data;
    bus.i_exec_ready   = ready;
    bus.i_pc_we        = we;
    bus.i_pc_increment = inc;
    bus.i_pc           = pc;
  endtask

  // ---------------- behavioural model ----------------
  // m_boot counts edges since reset release (request allowed from 2);
  // m_have means an instruction is held and awaiting retirement.
  int          m_boot    = 0;
  logic        m_have    = 1'b0;
  logic [15:0] m_pc      = RST_PC;
  logic [15:0] m_instr   = 16'h0000;
  logic [15:0] m_retired = 16'h0000;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_boot = 0; m_have = 1'b0; m_pc = RST_PC; m_instr = 16'h0000; m_retired = 16'h0000;
    end else if (m_boot < 2) begin
      m_boot = m_boot + 1;
    end else if (!m_have) begin
      if (bus.i_imem_ack) begin
        m_instr = bus.i_imem_data;
        m_have  = 1'b1;
      end
    end else if (bus.i_exec_ready) begin
      if (bus.i_pc_we)             m_pc = bus.i_pc;
      else if (bus.i_pc_increment) m_pc = 16'((32'(m_pc) + 1) % 65536);
      m_retired = 16'((32'(m_retired) + 1) % 65536);
      m_have    = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    if (cmp_en) begin
      fetch_state_e exp_state;
      logic         exp_req;
      exp_req   = (m_boot >= 2) && !m_have;
      exp_state = (m_boot < 2) ? RESET : (m_have ? HOLD : FETCH);
      check("m_req",     32'(bus.o_imem_req),    32'(exp_req));
      check("m_valid",   32'(bus.o_instr_valid), 32'(m_have));
      check("m_addr",    32'(bus.o_imem_addr),   32'(m_pc));
      check("m_pc",      32'(bus.o_pc),          32'(m_pc));
      check("m_instr",   32'(bus.o_instr),       32'(m_instr));
      check("m_retired", 32'(bus.o_retired),     32'(m_retired));
      check("m_state",   32'(dbg_state),         32'(exp_state));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},     32'(bus.o_imem_req),    32'h0);
    check({tag, "_valid"},   32'(bus.o_instr_valid), 32'h0);
    check({tag, "_addr"},    32'(bus.o_imem_addr),   32'(RST_PC));
    check({tag, "_pc"},      32'(bus.o_pc),          32'(RST_PC));
    check({tag, "_instr"},   32'(bus.o_instr),       32'h0);
    check({tag, "_retired"}, 32'(bus.o_retired),     32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge i_clk);
    cmp_en = 1'b1;
    check_reset_values("rst");

    // Zero-wait memory, ready tied high, increment each retire.
    drive(1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("boot_req_low", 32'(bus.o_imem_req), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("zw_req",  32'(bus.o_imem_req),  32'h1);
      check("zw_addr", 32'(bus.o_imem_addr), 32'(k));
      @(negedge i_clk);
      check("zw_valid", 32'(bus.o_instr_valid), 32'h1);
      check("zw_instr", 32'(bus.o_instr),       32'h0005);
    end
    @(negedge i_clk);
    check("zw_retired", 32'(bus.o_retired),   32'd3);
    check("zw_addr3",   32'(bus.o_imem_addr), 32'h0003);

    // Three wait cycles before ack.
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) begin
      @(negedge i_clk);
      check("wait_req",   32'(bus.o_imem_req),    32'h1);
      check("wait_addr",  32'(bus.o_imem_addr),   32'h0003);
      check("wait_valid", 32'(bus.o_instr_valid), 32'h0);
    end
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge i_clk);
    check("ack_valid", 32'(bus.o_instr_valid), 32'h1);
    check("ack_instr", 32'(bus.o_instr),       32'h1234);

    // Stall in HOLD with stray acks and redirect inputs that must be ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1'(i % 2), 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h0777);
      @(negedge i_clk);
      check("hold_instr", 32'(bus.o_instr),    32'h1234);
      check("hold_pc",    32'(bus.o_pc),       32'h0003);
      check("hold_req",   32'(bus.o_imem_req), 32'h0);
    end

    // Jump wins over increment.
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0040);
    @(negedge i_clk);
    check("jmp_addr",    32'(bus.o_imem_addr),   32'h0040);
    check("jmp_req",     32'(bus.o_imem_req),    32'h1);
    check("jmp_valid",   32'(bus.o_instr_valid), 32'h0);
    check("jmp_retired", 32'(bus.o_retired),     32'd4);

    // Increment from FFFF wraps to 0000.
    drive(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge i_clk);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    @(negedge i_clk);
    check("top_addr", 32'(bus.o_imem_addr), 32'hFFFF);
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge i_clk);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0);
    @(negedge i_clk);
    check("wrap_addr",    32'(bus.o_imem_addr), 32'h0000);
    check("wrap_retired", 32'(bus.o_retired),   32'd6);

    // Reset while waiting for an ack at 0x0010; late ack during reset.
    drive(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge i_clk);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0010);
    @(negedge i_clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge i_clk);
    check("pre_rst_addr", 32'(bus.o_imem_addr), 32'h0010);
    check("pre_rst_req",  32'(bus.o_imem_req),  32'h1);
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("late_ack_req",   32'(bus.o_imem_req), 32'h0);
    check("late_ack_instr", 32'(bus.o_instr),    32'h0);
    @(negedge i_clk);
    check("restart_addr", 32'(bus.o_imem_addr), 32'(RST_PC));
    check("restart_req",  32'(bus.o_imem_req),  32'h1);

    // Randomized run, with one asynchronous reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 2))) : 16'($urandom);
      drive(1'($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), tgt);
      if (c == 2000) begin
        #2 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
      end
      @(negedge i_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
